jtag_reg_sequencer: RTL and testbench



---
 rtl/jtag_reg_pkg.sv | 50 +++++
 rtl/bus_sync.sv | 37 +++
 rtl/jtag_reg_sequencer.sv | 196 +++++++++++++++++++
 tb/tb_jtag_reg_sequencer.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jtag_reg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : jtag_reg_pkg
// Description : Shared types and field-position helpers for the JTAG
//               register-bus sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package jtag_reg_pkg;

    // Command opcode carried in the two bits below the toggle
    typedef enum logic [1:0] {
        OP_NOP     = 2'b00,
        OP_WRITE   = 2'b01,
        OP_READ    = 2'b10,
        OP_ILLEGAL = 2'b11
    } op_e;

    // Sequencer states
    typedef enum logic [1:0] {
        ARM  = 2'd0,
        IDLE = 2'd1,
        REQ  = 2'd2,
        DONE = 2'd3
    } state_e;

    // Shared counter width: covers the full TIMEOUT range 1..65535
    localparam int c_cnt_width = 16;

    // Total command/status word width
    function automatic int cmd_width(input int aw, input int dw);
        return aw + dw + 4;
    endfunction

    // Toggle / ack_toggle bit position (T)
    function automatic int tog_pos(input int aw, input int dw);
        return aw + dw + 3;
    endfunction

    // Low bit of the two-bit op field (op occupies [T-1:T-2])
    function automatic int op_lo_pos(input int aw, input int dw);
        return aw + dw + 1;
    endfunction

    // Reserved bit position (T-3) in the command word
    function automatic int rsvd_pos(input int aw, input int dw);
        return aw + dw;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bus_sync.sv
`default_nettype none
// ============================================================================
// Module      : bus_sync
// Description : Parameterised flop chain used to bring a bus into the clk
//               domain (or to delay an already-synchronised bit).
// Revision    : 1.0 - initial release
// ============================================================================
module bus_sync #(
    parameter int WIDTH  = 1,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] r_chain [STAGES];

    // Shift the input through STAGES registers; all stages clear on reset
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < STAGES; i++) begin
                r_chain[i] <= '0;
            end
        end else begin
            r_chain[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                r_chain[i] <= r_chain[i-1];
            end
        end
    end

    assign q = r_chain[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/jtag_reg_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : jtag_reg_sequencer
// Description : Turns a toggle-qualified JTAG command word into a single
//               register-bus read/write with timeout and reports the result
//               plus an acknowledge toggle through the status word.
// Revision    : 1.0 - initial release
// ============================================================================
module jtag_reg_sequencer
    import jtag_reg_pkg::*;
#(
    parameter int ADDR_WIDTH  = 8,
    parameter int DATA_WIDTH  = 16,
    parameter int TIMEOUT     = 255,
    parameter int SYNC_STAGES = 2,
    localparam int CMD_WIDTH  = ADDR_WIDTH + DATA_WIDTH + 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [CMD_WIDTH-1:0]  control,
    output logic [CMD_WIDTH-1:0]  status,
    output logic                  bus_req,
    output logic                  bus_we,
    output logic [ADDR_WIDTH-1:0] bus_addr,
    output logic [DATA_WIDTH-1:0] bus_wdata,
    input  logic                  bus_ack,
    input  logic [DATA_WIDTH-1:0] bus_rdata
);

    localparam int c_tog   = tog_pos(ADDR_WIDTH, DATA_WIDTH);
    localparam int c_op_lo = op_lo_pos(ADDR_WIDTH, DATA_WIDTH);
    localparam int c_rsvd  = rsvd_pos(ADDR_WIDTH, DATA_WIDTH);
    // ARM waits until the whole chain, including the toggle stage, holds
    // post-reset samples, then adopts the host toggle on the following cycle
    localparam logic [c_cnt_width-1:0] c_arm_last     = c_cnt_width'(SYNC_STAGES + 1);
    localparam logic [c_cnt_width-1:0] c_timeout_last = c_cnt_width'(TIMEOUT - 1);

    logic [CMD_WIDTH-1:0]   w_cmd_s;
    logic                   w_tog_s;
    op_e                    w_cmd_op;
    logic                   w_unused_rsvd;

    state_e                 r_state;
    state_e                 w_next;
    logic                   w_capture;
    logic                   w_arm_done;
    logic                   w_timeout_hit;

    logic [c_cnt_width-1:0] r_cnt;
    logic                   r_last_tog;
    op_e                    r_op;
    logic [ADDR_WIDTH-1:0]  r_addr;
    logic [DATA_WIDTH-1:0]  r_wdata;
    logic [DATA_WIDTH-1:0]  r_result;
    logic                   r_timed_out;

    logic                   r_ack_toggle;
    logic                   r_busy;
    logic                   r_err_timeout;
    logic                   r_err_op;
    logic [ADDR_WIDTH-1:0]  r_stat_addr;
    logic [DATA_WIDTH-1:0]  r_stat_data;

    // Whole control word through the synchroniser
    bus_sync #(.WIDTH(CMD_WIDTH), .STAGES(SYNC_STAGES)) u_cmd_sync (
        .clk (clk),
        .rst (rst),
        .d   (control),
        .q   (w_cmd_s)
    );

    // Extra stage on the toggle so cmd_s is settled when the edge is seen
    bus_sync #(.WIDTH(1), .STAGES(1)) u_tog_sync (
        .clk (clk),
        .rst (rst),
        .d   (w_cmd_s[c_tog]),
        .q   (w_tog_s)
    );

    assign w_cmd_op      = op_e'(w_cmd_s[c_op_lo+1:c_op_lo]);
    assign w_unused_rsvd = w_cmd_s[c_rsvd];

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ARM;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode and per-state strobes
    always_comb begin
        w_next        = r_state;
        w_capture     = 1'b0;
        w_arm_done    = 1'b0;
        w_timeout_hit = 1'b0;
        case (r_state)
            ARM: begin
                if (r_cnt == c_arm_last) begin
                    w_arm_done = 1'b1;
                    w_next     = IDLE;
                end
            end
            IDLE: begin
                if (w_tog_s != r_last_tog) begin
                    w_capture = 1'b1;
                    w_next    = (w_cmd_op == OP_WRITE || w_cmd_op == OP_READ) ? REQ : DONE;
                end
            end
            REQ: begin
                // Ack wins over a timeout expiring in the same cycle
                if (bus_ack) begin
                    w_next = DONE;
                end else if (r_cnt == c_timeout_last) begin
                    w_timeout_hit = 1'b1;
                    w_next        = DONE;
                end
            end
            DONE: begin
                w_next = IDLE;
            end
            default: begin
                w_next = ARM;
            end
        endcase
    end

    // Command capture, bus result tracking and status update
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt         <= '0;
            r_last_tog    <= 1'b0;
            r_op          <= OP_NOP;
            r_addr        <= '0;
            r_wdata       <= '0;
            r_result      <= '0;
            r_timed_out   <= 1'b0;
            r_ack_toggle  <= 1'b0;
            r_busy        <= 1'b0;
            r_err_timeout <= 1'b0;
            r_err_op      <= 1'b0;
            r_stat_addr   <= '0;
            r_stat_data   <= '0;
        end else begin
            if (w_arm_done) begin
                // Adopt whatever toggle the host left behind: no stale replay
                r_last_tog   <= w_tog_s;
                r_ack_toggle <= w_tog_s;
            end else if (r_state == ARM) begin
                r_cnt <= r_cnt + 1'b1;
            end

            if (w_capture) begin
                r_last_tog    <= w_tog_s;
                r_busy        <= 1'b1;
                r_err_timeout <= 1'b0;
                r_err_op      <= 1'b0;
                r_op          <= w_cmd_op;
                r_addr        <= w_cmd_s[DATA_WIDTH+ADDR_WIDTH-1:DATA_WIDTH];
                r_wdata       <= w_cmd_s[DATA_WIDTH-1:0];
                r_result      <= '0;
                r_timed_out   <= 1'b0;
                r_cnt         <= '0;
            end

            if (r_state == REQ) begin
                if (bus_ack) begin
                    r_result <= (r_op == OP_WRITE) ? r_wdata : bus_rdata;
                end else if (w_timeout_hit) begin
                    r_timed_out <= 1'b1;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end

            if (r_state == DONE) begin
                r_busy        <= 1'b0;
                r_err_timeout <= r_timed_out;
                r_err_op      <= (r_op == OP_ILLEGAL);
                r_stat_addr   <= r_addr;
                r_stat_data   <= r_result;
                r_ack_toggle  <= r_last_tog;
            end
        end
    end

    assign bus_req   = (r_state == REQ);
    assign bus_we    = bus_req && (r_op == OP_WRITE);
    assign bus_addr  = bus_req ? r_addr  : '0;
    assign bus_wdata = bus_req ? r_wdata : '0;

    assign status = {r_ack_toggle, r_busy, r_err_timeout, r_err_op, r_stat_addr, r_stat_data};

endmodule
`default_nettype wire

// File: tb/tb_jtag_reg_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_jtag_reg_sequencer
// Description : Self-checking bench: directed vector table, randomized
//               transactions against a transaction-level model, and
//               hand-written multi-cycle corner sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_jtag_reg_sequencer;

    localparam int AW = 8;
    localparam int DW = 16;
    localparam int TO = 255;
    localparam int SS = 2;
    localparam int CW = AW + DW + 4;
    localparam int T  = CW - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic [CW-1:0] control;
    logic [CW-1:0] status;
    logic          bus_req;
    logic          bus_we;
    logic [AW-1:0] bus_addr;
    logic [DW-1:0] bus_wdata;
    logic          bus_ack;
    logic [DW-1:0] bus_rdata;

    always #5 clk = ~clk;

    jtag_reg_sequencer #(
        .ADDR_WIDTH  (AW),
        .DATA_WIDTH  (DW),
        .TIMEOUT     (TO),
        .SYNC_STAGES (SS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .control   (control),
        .status    (status),
        .bus_req   (bus_req),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_ack   (bus_ack),
        .bus_rdata (bus_rdata)
    );

    // One transaction: stimulus plus expected outcome
    typedef struct {
        logic [1:0]  op;
        logic [7:0]  addr;
        logic [15:0] wdata;
        int          ack_dly;   // req cycle in which ack is given, 0 = never
        logic [15:0] rdata;
        bit          exp_req;
        int          exp_req_cycles;
        bit          exp_err_to;
        bit          exp_err_op;
        logic [15:0] exp_data;
    } vec_t;

    int            checks = 0;
    int            errors = 0;
    logic          host_tog;
    logic [CW-1:0] exp_status;
    vec_t          tbl [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_range(input string name, input int v, input int lo, input int hi);
        checks++;
        if (v < lo || v > hi) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, v, lo, hi);
        end
    endtask

    function automatic vec_t mk(input logic [1:0] op, input logic [7:0] addr,
                                input logic [15:0] wdata, input int ack_dly,
                                input logic [15:0] rdata, input bit ereq, input int ecyc,
                                input bit eto, input bit eop, input logic [15:0] edata);
        vec_t v;
        v.op = op; v.addr = addr; v.wdata = wdata; v.ack_dly = ack_dly; v.rdata = rdata;
        v.exp_req = ereq; v.exp_req_cycles = ecyc; v.exp_err_to = eto;
        v.exp_err_op = eop; v.exp_data = edata;
        return v;
    endfunction

    // Transaction-level reference: outcome follows from the op and when (if ever) ack comes
    function automatic vec_t model(input logic [1:0] op, input logic [7:0] addr,
                                   input logic [15:0] wdata, input int ack_dly,
                                   input logic [15:0] rdata);
        bit is_bus;
        bit acked;
        is_bus = (op == 2'b01) || (op == 2'b10);
        acked  = is_bus && (ack_dly >= 1) && (ack_dly <= TO);
        return mk(op, addr, wdata, ack_dly, rdata, is_bus, acked ? ack_dly : TO,
                  is_bus && !acked, op == 2'b11,
                  acked ? ((op == 2'b01) ? wdata : rdata) : 16'h0000);
    endfunction

    // Wait (bounded) for bus_req, returning at the negedge where it is first high
    task automatic wait_req(input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus_req && n < 20);
        chk(name, bus_req, 1'b1);
    endtask

    // Issue one command via a toggle flip, act as register file, check the result
    task automatic run_txn(input vec_t v);
        int waited;
        int first_req;
        int req_cycles;
        int ack_at;
        bit seen_req;
        bit seen_busy;
        bit beat_ok;
        host_tog = ~host_tog;
        control  = {host_tog, v.op, 1'($urandom_range(0, 1)), v.addr, v.wdata};
        waited = 0; first_req = 0; req_cycles = 0; ack_at = -1;
        seen_req = 1'b0; seen_busy = 1'b0; beat_ok = 1'b1;
        while (status[T] != host_tog && waited < TO + 40) begin
            @(negedge clk);
            waited++;
            bus_ack   = 1'b0;
            bus_rdata = 16'($urandom);
            if (status[T-1]) seen_busy = 1'b1;
            if (bus_req) begin
                if (!seen_req) first_req = waited;
                seen_req = 1'b1;
                req_cycles++;
                if (bus_we !== (v.op == 2'b01) || bus_addr !== v.addr || bus_wdata !== v.wdata)
                    beat_ok = 1'b0;
                if (req_cycles == v.ack_dly) begin
                    bus_ack   = 1'b1;
                    bus_rdata = v.rdata;
                    ack_at    = waited;
                end
            end
        end
        bus_ack = 1'b0;
        chk("ack_flip", status[T], host_tog);
        chk("req_seen", seen_req, v.exp_req);
        chk("busy_seen", seen_busy, 1'b1);
        if (v.exp_req) begin
            chk_range("req_latency", first_req, SS + 1, SS + 3);
            chk("req_cycles", req_cycles, v.exp_req_cycles);
            chk("req_fields", beat_ok, 1'b1);
            if (ack_at >= 0) chk_range("ack_to_flip", waited - ack_at, 1, 2);
        end else begin
            chk_range("nocmd_flip_latency", waited, SS + 2, SS + 4);
        end
        exp_status = {host_tog, 1'b0, v.exp_err_to, v.exp_err_op, v.addr, v.exp_data};
        chk("status", status, exp_status);
    endtask

    initial begin
        bit any_req;
        int g;
        logic t1;
        vec_t v;

        tbl[0] = mk(2'b01, 8'h12, 16'hBEEF, 3,   16'h0000, 1'b1, 3,   1'b0, 1'b0, 16'hBEEF);
        tbl[1] = mk(2'b10, 8'h34, 16'h1111, 2,   16'hA5C3, 1'b1, 2,   1'b0, 1'b0, 16'hA5C3);
        tbl[2] = mk(2'b10, 8'h56, 16'h0000, 0,   16'h0000, 1'b1, TO,  1'b1, 1'b0, 16'h0000);
        tbl[3] = mk(2'b10, 8'h9A, 16'h2222, TO,  16'h0F0F, 1'b1, TO,  1'b0, 1'b0, 16'h0F0F);
        tbl[4] = mk(2'b00, 8'h21, 16'h5555, 0,   16'h0000, 1'b0, 0,   1'b0, 1'b0, 16'h0000);
        tbl[5] = mk(2'b11, 8'h43, 16'hFFFF, 0,   16'h0000, 1'b0, 0,   1'b0, 1'b1, 16'h0000);
        tbl[6] = mk(2'b01, 8'hFF, 16'h0001, 1,   16'h0000, 1'b1, 1,   1'b0, 1'b0, 16'h0001);

        rst = 1'b1; control = '0; bus_ack = 1'b0; bus_rdata = '0; host_tog = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset state and quiet idle
        repeat (4) @(negedge clk);
        chk("reset_status", status, '0);
        chk("reset_req", bus_req, 1'b0);
        any_req = 1'b0;
        repeat (100) begin
            @(negedge clk);
            if (bus_req) any_req = 1'b1;
        end
        chk("idle_no_req", any_req, 1'b0);
        exp_status = '0;

        // Directed vectors
        for (int i = 0; i < 7; i++) run_txn(tbl[i]);

        // Spurious ack outside REQ must change nothing
        bus_ack = 1'b1;
        @(negedge clk);
        bus_ack = 1'b0;
        repeat (3) @(negedge clk);
        chk("stray_ack_req", bus_req, 1'b0);
        chk("stray_ack_status", status, exp_status);

        // Randomized transactions
        for (int i = 0; i < 40; i++) begin
            v = model(2'($urandom_range(0, 3)), 8'($urandom), 16'($urandom),
                      $urandom_range(1, 6), 16'($urandom));
            run_txn(v);
        end

        // Toggle flipped while the first command is still in REQ
        host_tog = ~host_tog;
        t1 = host_tog;
        control = {t1, 2'b10, 1'b0, 8'h55, 16'h0000};
        wait_req("b2b_first_req");
        host_tog = ~host_tog;
        control = {host_tog, 2'b01, 1'b0, 8'h66, 16'h1234};
        repeat (7) @(negedge clk);
        bus_ack = 1'b1; bus_rdata = 16'h7777;
        @(negedge clk);
        bus_ack = 1'b0;
        chk("b2b_req_drop", bus_req, 1'b0);
        g = 0;
        while (!bus_req && g < 10) begin
            @(negedge clk);
            g++;
        end
        chk("b2b_gap", g, 2);
        chk("b2b_mid_status", status, {t1, 1'b1, 2'b00, 8'h55, 16'h7777});
        chk("b2b_second_fields", {bus_we, bus_addr, bus_wdata}, {1'b1, 8'h66, 16'h1234});
        bus_ack = 1'b1;
        @(negedge clk);
        bus_ack = 1'b0;
        g = 0;
        while (status[T] != host_tog && g < 10) begin
            @(negedge clk);
            g++;
        end
        exp_status = {host_tog, 1'b0, 2'b00, 8'h66, 16'h1234};
        chk("b2b_final_status", status, exp_status);

        // Reset in the middle of REQ
        host_tog = ~host_tog;
        control = {host_tog, 2'b01, 1'b0, 8'h77, 16'hCAFE};
        wait_req("rst_mid_req_wait");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_req_drop", bus_req, 1'b0);
        chk("rst_status_clear", status, '0);
        @(negedge clk);
        rst = 1'b0;
        any_req = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (bus_req) any_req = 1'b1;
        end
        chk("rst_no_replay", any_req, 1'b0);
        chk("rst_ack_adopt", status, {host_tog, 27'h0});

        // Host toggle already 1 when reset releases
        rst = 1'b1;
        host_tog = 1'b1;
        control = {1'b1, 2'b10, 1'b0, 8'hAB, 16'h0000};
        repeat (3) @(negedge clk);
        rst = 1'b0;
        any_req = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (bus_req) any_req = 1'b1;
        end
        chk("stale_no_req", any_req, 1'b0);
        chk("stale_ack_toggle", status, {1'b1, 27'h0});

        // Normal operation resumes afterwards
        run_txn(mk(2'b01, 8'h3C, 16'h0BAD, 2, 16'h0000, 1'b1, 2, 1'b0, 1'b0, 16'h0BAD));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
